// File: rtl/lsb_queue.sv
// In-order load/store buffer sitting between issue, the ROB and the memory controller.
// Only the head slot talks to memory. Committed stores survive a rollback.
module lsb_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned OP_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_i,
    input  logic             issue_valid_i,
    input  logic [OP_W-1:0]  issue_op_i,
    input  logic [ROB_W-1:0] issue_entry_i,
    input  logic [31:0]      issue_vj_i,
    input  logic [31:0]      issue_vk_i,
    input  logic [ROB_W-1:0] issue_qj_i,
    input  logic [ROB_W-1:0] issue_qk_i,
    input  logic [31:0]      issue_imm_i,
    output logic             full_o,
    input  logic             alu_valid_i,
    input  logic [ROB_W-1:0] alu_entry_i,
    input  logic [31:0]      alu_value_i,
    input  logic             commit_valid_i,
    input  logic [ROB_W-1:0] commit_entry_i,
    input  logic [31:0]      commit_value_i,
    input  logic             commit_store_i,
    input  logic             rollback_i,
    output logic             ld_valid_o,
    output logic [ROB_W-1:0] ld_entry_o,
    output logic [31:0]      ld_value_o,
    output logic             st_ready_o,
    output logic [ROB_W-1:0] st_entry_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [OP_W-1:0]  mem_op_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [ROB_W-1:0] NULL_TAG = {ROB_W{1'b1}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    // Opcodes LB=0, LH=1, LW=2, LBU=3, LHU=4 are loads; everything above is a store.
    localparam logic [OP_W-1:0]  OP_LHU   = OP_W'(4);

    localparam logic [2:0] StEmpty = 3'd0;
    localparam logic [2:0] StWait  = 3'd1;
    localparam logic [2:0] StRes   = 3'd2;
    localparam logic [2:0] StComm  = 3'd3;
    localparam logic [2:0] StMem   = 3'd4;

    logic [2:0]       st_q    [DEPTH];
    logic [2:0]       st_d    [DEPTH];
    logic [OP_W-1:0]  op_q    [DEPTH];
    logic [OP_W-1:0]  op_d    [DEPTH];
    logic [ROB_W-1:0] entry_q [DEPTH];
    logic [ROB_W-1:0] entry_d [DEPTH];
    logic [31:0]      vj_q    [DEPTH];
    logic [31:0]      vj_d    [DEPTH];
    logic [31:0]      vk_q    [DEPTH];
    logic [31:0]      vk_d    [DEPTH];
    logic [ROB_W-1:0] qj_q    [DEPTH];
    logic [ROB_W-1:0] qj_d    [DEPTH];
    logic [ROB_W-1:0] qk_q    [DEPTH];
    logic [ROB_W-1:0] qk_d    [DEPTH];
    logic [31:0]      imm_q   [DEPTH];
    logic [31:0]      imm_d   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [OP_W-1:0]  mem_op_q, mem_op_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic             ld_valid_q, ld_valid_d;
    logic [ROB_W-1:0] ld_entry_q, ld_entry_d;
    logic [31:0]      ld_value_q, ld_value_d;
    logic             st_ready_q, st_ready_d;
    logic [ROB_W-1:0] st_entry_q, st_entry_d;
    // Set when a rollback abandons a load request; swallows that load's late ack.
    logic             drop_q, drop_d;

    logic             ack_take, pop, push, keep_run;
    logic [PTR_W:0]   kept;
    logic [PTR_W-1:0] idx, off, h;

    assign full_o      = (count_q == CNT_FULL);
    assign ld_valid_o  = ld_valid_q & ~(rollback_i & rdy_i);
    assign ld_entry_o  = ld_entry_q;
    assign ld_value_o  = ld_value_q;
    assign st_ready_o  = st_ready_q & ~(rollback_i & rdy_i);
    assign st_entry_o  = st_entry_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_op_o    = mem_op_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op <= OP_LHU;
    endfunction

    // Returns {tag, value}; a pending tag matching any live broadcast becomes ready.
    function automatic logic [ROB_W+31:0] wake(input logic [ROB_W-1:0] q, input logic [31:0] v);
        logic [ROB_W+31:0] r;
        r = {q, v};
        if (q != NULL_TAG) begin
            if (alu_valid_i && alu_entry_i == q) begin
                r = {NULL_TAG, alu_value_i};
            end else if (ld_valid_o && ld_entry_q == q) begin
                r = {NULL_TAG, ld_value_q};
            end else if (commit_valid_i && commit_entry_i == q) begin
                r = {NULL_TAG, commit_value_i};
            end
        end
        return r;
    endfunction

    always_comb begin
        st_d    = st_q;
        op_d    = op_q;
        entry_d = entry_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        imm_d   = imm_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_valid_d  = 1'b0;
        ld_entry_d  = ld_entry_q;
        ld_value_d  = ld_value_q;
        st_ready_d  = 1'b0;
        st_entry_d  = st_entry_q;
        drop_d      = drop_q;
        push        = 1'b0;
        keep_run    = 1'b1;
        kept        = '0;
        idx         = '0;
        off         = '0;
        h           = head_q;

        for (int i = 0; i < int'(DEPTH); i++) begin
            {qj_d[i], vj_d[i]} = wake(qj_q[i], vj_q[i]);
            {qk_d[i], vk_d[i]} = wake(qk_q[i], vk_q[i]);
            if (st_q[i] == StRes && commit_valid_i && commit_store_i &&
                commit_entry_i == entry_q[i]) begin
                st_d[i] = StComm;
            end
        end

        ack_take = mem_ack_i && mem_req_q && !drop_q;
        if (mem_ack_i && drop_q) begin
            drop_d = 1'b0;
        end
        pop = ack_take && (mem_we_q || !rollback_i);

        if (pop) begin
            st_d[h]   = StEmpty;
            mem_req_d = 1'b0;
            head_d    = head_q + PTR_ONE;
            if (!mem_we_q) begin
                ld_valid_d = 1'b1;
                ld_entry_d = entry_q[h];
                ld_value_d = mem_rdata_i;
            end
        end else if (!mem_req_q) begin
            case (st_q[h])
                StWait: begin
                    if (qj_q[h] == NULL_TAG && qk_q[h] == NULL_TAG) begin
                        if (is_load(op_q[h])) begin
                            st_d[h]     = StMem;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b0;
                            mem_op_d    = op_q[h];
                            mem_addr_d  = vj_q[h] + imm_q[h];
                            mem_wdata_d = '0;
                        end else begin
                            st_d[h]    = StRes;
                            st_ready_d = 1'b1;
                            st_entry_d = entry_q[h];
                        end
                    end
                end
                StComm: begin
                    st_d[h]     = StMem;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_op_d    = op_q[h];
                    mem_addr_d  = vj_q[h] + imm_q[h];
                    mem_wdata_d = vk_q[h];
                end
                default: ;
            endcase
        end

        if (rollback_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx = head_q + PTR_W'(i);
                if (keep_run && (PTR_W+1)'(i) < count_q &&
                    (st_q[idx] == StComm || (st_q[idx] == StMem && !is_load(op_q[idx])))) begin
                    kept = kept + (PTR_W+1)'(1);
                end else begin
                    keep_run = 1'b0;
                end
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                off = PTR_W'(i) - head_q;
                if ({1'b0, off} >= kept) begin
                    st_d[i] = StEmpty;
                end
            end
            if (mem_req_q && !mem_we_q && !mem_ack_i) begin
                drop_d = 1'b1;
            end
            if (!mem_we_d) begin
                mem_req_d = 1'b0;
            end
            ld_valid_d = 1'b0;
            st_ready_d = 1'b0;
            tail_d     = head_q + kept[PTR_W-1:0];
            count_d    = kept - (PTR_W+1)'(pop);
        end else begin
            // A push into a full queue is accepted only when the head frees a slot this cycle.
            push = issue_valid_i && (!full_o || pop);
            if (push) begin
                st_d[tail_q]    = StWait;
                op_d[tail_q]    = issue_op_i;
                entry_d[tail_q] = issue_entry_i;
                imm_d[tail_q]   = issue_imm_i;
                {qj_d[tail_q], vj_d[tail_q]} = wake(issue_qj_i, issue_vj_i);
                {qk_d[tail_q], vk_d[tail_q]} = wake(issue_qk_i, issue_vk_i);
                tail_d = tail_q + PTR_ONE;
            end
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                st_q[i]    <= StEmpty;
                op_q[i]    <= '0;
                entry_q[i] <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                imm_q[i]   <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_op_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_valid_q  <= 1'b0;
            ld_entry_q  <= '0;
            ld_value_q  <= '0;
            st_ready_q  <= 1'b0;
            st_entry_q  <= '0;
            drop_q      <= 1'b0;
        end else if (rdy_i) begin
            st_q        <= st_d;
            op_q        <= op_d;
            entry_q     <= entry_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            imm_q       <= imm_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_entry_q  <= ld_entry_d;
            ld_value_q  <= ld_value_d;
            st_ready_q  <= st_ready_d;
            st_entry_q  <= st_entry_d;
            drop_q      <= drop_d;
        end
    end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: loads, stores, wakeup, full/wrap, rollback, rdy stall.
module tb_lsb_queue;

    localparam logic [3:0] NUL = 4'hF;
    localparam logic [5:0] LW  = 6'd2;
    localparam logic [5:0] SW  = 6'd7;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid;
    logic [5:0]  issue_op;
    logic [3:0]  issue_entry, issue_qj, issue_qk;
    logic [31:0] issue_vj, issue_vk, issue_imm;
    logic        full;
    logic        alu_valid;
    logic [3:0]  alu_entry;
    logic [31:0] alu_value;
    logic        commit_valid, commit_store;
    logic [3:0]  commit_entry;
    logic [31:0] commit_value;
    logic        rollback;
    logic        ld_valid, st_ready, mem_req, mem_we, mem_ack;
    logic [3:0]  ld_entry, st_entry;
    logic [31:0] ld_value, mem_addr, mem_wdata, mem_rdata;
    logic [5:0]  mem_op;

    int checks = 0;
    int errors = 0;

    lsb_queue #(.DEPTH(16), .ROB_W(4), .OP_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy_i         (rdy),
        .issue_valid_i (issue_valid),
        .issue_op_i    (issue_op),
        .issue_entry_i (issue_entry),
        .issue_vj_i    (issue_vj),
        .issue_vk_i    (issue_vk),
        .issue_qj_i    (issue_qj),
        .issue_qk_i    (issue_qk),
        .issue_imm_i   (issue_imm),
        .full_o        (full),
        .alu_valid_i   (alu_valid),
        .alu_entry_i   (alu_entry),
        .alu_value_i   (alu_value),
        .commit_valid_i(commit_valid),
        .commit_entry_i(commit_entry),
        .commit_value_i(commit_value),
        .commit_store_i(commit_store),
        .rollback_i    (rollback),
        .ld_valid_o    (ld_valid),
        .ld_entry_o    (ld_entry),
        .ld_value_o    (ld_value),
        .st_ready_o    (st_ready),
        .st_entry_o    (st_entry),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_op_o      (mem_op),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        issue_valid  = 1'b0;
        alu_valid    = 1'b0;
        commit_valid = 1'b0;
        commit_store = 1'b0;
        rollback     = 1'b0;
        mem_ack      = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [3:0] e, input logic [31:0] vj,
                         input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk,
                         input logic [31:0] imm);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_entry = e;
        issue_vj    = vj;
        issue_vk    = vk;
        issue_qj    = qj;
        issue_qk    = qk;
        issue_imm   = imm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        clr();
        issue(LW, 0, 0, 0, NUL, NUL, 0);
        issue_valid = 1'b0;
        alu_entry = 0; alu_value = 0; commit_entry = 0; commit_value = 0; mem_rdata = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_full", full, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ld_valid", ld_valid, 0);
        chk("rst_st_ready", st_ready, 0);

        // Asynchronous reset while a load is in MEM
        issue(LW, 1, 32'h100, 0, NUL, NUL, 8); tick(); clr(); tick();
        chk("mid_mem_req", mem_req, 1);
        rst = 1'b1; #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_full", full, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_ld_valid", ld_valid, 0);
            chk("post_rst_req", mem_req, 0);
        end

        // Ready load
        issue(LW, 2, 32'h100, 0, NUL, NUL, 8); tick(); clr(); tick();
        chk("lw_req", mem_req, 1);
        chk("lw_addr", mem_addr, 32'h108);
        chk("lw_we", mem_we, 0);
        chk("lw_op", mem_op, 32'(LW));
        tick();
        chk("lw_req_hold", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; tick(); clr();
        chk("lw_ld_valid", ld_valid, 1);
        chk("lw_ld_entry", ld_entry, 2);
        chk("lw_ld_value", ld_value, 32'hDEADBEEF);
        chk("lw_req_drop", mem_req, 0);
        tick();
        chk("lw_ld_pulse", ld_valid, 0);

        // Store waiting on Qk, woken by ALU, then committed
        issue(SW, 4, 32'h200, 0, NUL, 3, 4); tick(); clr();
        alu_valid = 1'b1; alu_entry = 3; alu_value = 32'h55; tick(); clr();
        chk("sw_not_ready", st_ready, 0);
        tick();
        chk("sw_st_ready", st_ready, 1);
        chk("sw_st_entry", st_entry, 4);
        tick();
        chk("sw_st_pulse", st_ready, 0);
        chk("sw_no_req_precommit", mem_req, 0);
        commit_valid = 1'b1; commit_store = 1'b1; commit_entry = 4; tick(); clr(); tick();
        chk("sw_req", mem_req, 1);
        chk("sw_we", mem_we, 1);
        chk("sw_addr", mem_addr, 32'h204);
        chk("sw_wdata", mem_wdata, 32'h55);
        mem_ack = 1'b1; tick(); clr();
        chk("sw_done_req", mem_req, 0);
        chk("sw_done_full", full, 0);
        chk("sw_no_ld_valid", ld_valid, 0);

        // Fill to DEPTH, ignored push at full, pop with push at full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(SW, 4'(i), 32'h3000 + 32'(i), 32'(i), NUL, NUL, 0);
            tick();
            if (i == 14) chk("fill15_full", full, 0);
        end
        chk("fill16_full", full, 1);
        issue(SW, 9, 32'h9999, 0, NUL, NUL, 0); tick(); clr();
        chk("push17_ignored", full, 1);
        commit_valid = 1'b1; commit_store = 1'b1; commit_entry = 0; tick(); clr(); tick();
        chk("full_head_req", mem_req, 1);
        chk("full_head_addr", mem_addr, 32'h3000);
        mem_ack = 1'b1;
        issue(SW, 0, 32'h3100, 32'h99, NUL, NUL, 0); tick(); clr();
        chk("pop_push_full", full, 1);
        tick();
        chk("next_head_st_ready", st_ready, 1);
        chk("next_head_st_entry", st_entry, 1);
        commit_valid = 1'b1; commit_store = 1'b1; commit_entry = 1; tick(); clr(); tick();
        chk("next_head_addr", mem_addr, 32'h3001);
        chk("next_head_wdata", mem_wdata, 1);
        mem_ack = 1'b1; tick(); clr();
        chk("pop_only_not_full", full, 0);

        // Committed store in flight, loads behind it, rollback
        do_reset();
        issue(SW, 1, 32'h400, 32'h77, NUL, NUL, 0); tick();
        issue(LW, 2, 32'h500, 0, NUL, NUL, 0); tick();
        issue(LW, 3, 32'h504, 0, NUL, NUL, 0);
        commit_valid = 1'b1; commit_store = 1'b1; commit_entry = 1; tick(); clr();
        issue(LW, 4, 32'h508, 0, NUL, NUL, 0); tick(); clr();
        chk("rb_store_req", mem_req, 1);
        chk("rb_store_we", mem_we, 1);
        rollback = 1'b1; #1;
        chk("rb_ld_valid_forced", ld_valid, 0);
        tick(); clr();
        chk("rb_store_continues", mem_req, 1);
        chk("rb_store_wdata", mem_wdata, 32'h77);
        mem_ack = 1'b1; tick(); clr();
        chk("rb_store_done", mem_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rb_loads_flushed", mem_req, 0);
            chk("rb_no_ld_valid", ld_valid, 0);
        end
        issue(LW, 6, 32'h640, 0, NUL, NUL, 0); tick(); clr(); tick();
        chk("rb_tail_addr", mem_addr, 32'h640);
        mem_ack = 1'b1; mem_rdata = 32'h11; tick(); clr();
        chk("rb_new_ld_entry", ld_entry, 6);
        chk("rb_new_ld_valid", ld_valid, 1);

        // Rollback dropping an outstanding load; its late ack is ignored
        issue(LW, 7, 32'h700, 0, NUL, NUL, 0); tick(); clr(); tick();
        chk("drop_req", mem_req, 1);
        rollback = 1'b1; tick(); clr();
        chk("drop_req_cleared", mem_req, 0);
        mem_ack = 1'b1; mem_rdata = 32'h1234; tick(); clr();
        chk("drop_stale_ack", ld_valid, 0);
        issue(LW, 8, 32'h600, 0, NUL, NUL, 0); tick(); clr(); tick();
        chk("drop_next_addr", mem_addr, 32'h600);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE; tick(); clr();
        chk("drop_next_entry", ld_entry, 8);
        chk("drop_next_value", ld_value, 32'hCAFE);

        // ALU and commit waking Qj and Qk of one slot in the same cycle
        issue(SW, 9, 0, 0, 5, 6, 32'h20); tick(); clr();
        alu_valid = 1'b1; alu_entry = 5; alu_value = 32'h700;
        commit_valid = 1'b1; commit_entry = 6; commit_value = 32'hABCD; tick(); clr();
        tick();
        chk("dual_st_ready", st_ready, 1);
        commit_valid = 1'b1; commit_store = 1'b1; commit_entry = 9; tick(); clr(); tick();
        chk("dual_addr", mem_addr, 32'h720);
        chk("dual_wdata", mem_wdata, 32'hABCD);
        mem_ack = 1'b1; tick(); clr();

        // Issue bypass from a same-cycle ALU broadcast
        issue(LW, 10, 0, 0, 11, NUL, 4);
        alu_valid = 1'b1; alu_entry = 11; alu_value = 32'h800; tick(); clr(); tick();
        chk("bypass_req", mem_req, 1);
        chk("bypass_addr", mem_addr, 32'h804);
        mem_ack = 1'b1; mem_rdata = 32'h5A; tick(); clr();
        chk("bypass_value", ld_value, 32'h5A);

        // rdy=0 freezes state and ignores acks
        issue(LW, 12, 32'h900, 0, NUL, NUL, 0); tick(); clr();
        rdy = 1'b0; tick();
        chk("rdy_freeze_no_req", mem_req, 0);
        rdy = 1'b1; tick();
        chk("rdy_resume_req", mem_req, 1);
        rdy = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77; tick();
        chk("rdy_ack_ignored_req", mem_req, 1);
        chk("rdy_ack_ignored_ld", ld_valid, 0);
        rdy = 1'b1; tick(); clr();
        chk("rdy_ack_taken", ld_valid, 1);
        chk("rdy_ack_value", ld_value, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
